// File: rtl/frame_pkg.sv
// Shared types and default geometry for the frame capture controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_pkg;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  // Default frame geometry. Modules expose these as overridable parameters
  // named H_ACTIVE / V_ACTIVE / PIXEL_W, so the package copies carry a prefix
  // to keep the two name spaces apart.
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_PIXEL_W  = 7;
  localparam int DEF_ADDR_W   = 17;

  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

  localparam int DEF_FRAME_PIXELS = frame_pixels(DEF_H_ACTIVE, DEF_V_ACTIVE);

endpackage

// File: rtl/frame_addr_gen.sv
// Range-checks recovered pixels and turns (hcount, vcount) into a linear bank address.
// Latency: 1 cycle from qualifying pixel strobe to registered write strobe/address/data.
// Backpressure: none; the BRAM port always accepts, so every qualified pixel is written.
//
// Ports:
//   clk, rst           : system clock, synchronous active-high reset
//   capture_en         : controller is in a state where pixels may be written
//   pixel_valid, pixel : recovered pixel strobe and value
//   hcount, vcount     : pixel column / row
//   accept             : combinational, this cycle's pixel will be written
//   wr_en/addr/data    : registered BRAM write port
module frame_addr_gen
  import frame_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int PIXEL_W  = DEF_PIXEL_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_en,
  input  logic               pixel_valid,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  output logic               accept,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIXEL_W-1:0] wr_data
);

  localparam logic [10:0]       H_LIM    = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_ACTIVE);

  logic              in_range;
  logic [ADDR_W-1:0] addr_nxt;

  // Blanking / overscan positions are silently skipped.
  assign in_range = (hcount < H_LIM) && (vcount < V_LIM);
  assign accept   = capture_en && pixel_valid && in_range;

  // Row stride is a constant, so this reduces to a shift-add tree that fits
  // in the single pipeline stage ahead of the write register.
  assign addr_nxt = (ADDR_W'(vcount) * H_STRIDE) + ADDR_W'(hcount);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= addr_nxt;
        wr_data <= pixel;
      end
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Ping-pong frame-buffer write controller: frame-aligned capture into two BRAM banks with reader handoff.
// Latency: pixel to BRAM write 1 cycle; bank swap / ready visible the cycle after COMMIT.
// Backpressure: none on the pixel stream; a frame is dropped (counted) when the reader still holds its bank.
//
// Ports:
//   system_clk_in, rst_in          : 65 MHz system clock, synchronous active-high reset
//   pixel_in, data_valid_in        : recovered pixel and its single-cycle strobe
//   hcount_in, vcount_in           : pixel column / row
//   frame_done_in                  : end-of-frame pulse
//   capture_arm_in, continuous_in  : single-shot request pulse / continuous-capture level
//   read_release_in                : reader has finished with rd_bank_out
//   wr_en/addr/data/bank_out       : registered BRAM write port and target bank
//   rd_bank_out, frame_ready_out   : bank owned by the reader and whether it holds a complete frame
//   busy_out                       : capture in progress (WAIT_SOF or CAPTURE)
//   dropped_frames_out             : saturating count of frames that were not handed off
module frame_capture_ctrl
  import frame_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int PIXEL_W  = DEF_PIXEL_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic               system_clk_in,
  input  logic               rst_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               data_valid_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               frame_done_in,
  input  logic               capture_arm_in,
  input  logic               continuous_in,
  input  logic               read_release_in,
  output logic               wr_en_out,
  output logic [ADDR_W-1:0]  wr_addr_out,
  output logic [PIXEL_W-1:0] wr_data_out,
  output logic               wr_bank_out,
  output logic               rd_bank_out,
  output logic               frame_ready_out,
  output logic               busy_out,
  output logic [7:0]         dropped_frames_out
);

  localparam logic [16:0] FRAME_PIXELS = 17'(frame_pixels(H_ACTIVE, V_ACTIVE));

  state_t      state;
  state_t      state_nxt;
  logic        capture_en;
  logic        accept;
  logic [16:0] pix_cnt;
  logic        frame_complete;
  logic        reader_free;
  logic        wr_bank;
  logic        rd_bank;
  logic        frame_ready;
  logic [7:0]  dropped;

  // frame_done_in outranks a coincident pixel: that pixel belongs to no frame.
  assign capture_en = (state == CAPTURE) && !frame_done_in;

  frame_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .PIXEL_W  (PIXEL_W),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk         (system_clk_in),
    .rst         (rst_in),
    .capture_en  (capture_en),
    .pixel_valid (data_valid_in),
    .pixel       (pixel_in),
    .hcount      (hcount_in),
    .vcount      (vcount_in),
    .accept      (accept),
    .wr_en       (wr_en_out),
    .wr_addr     (wr_addr_out),
    .wr_data     (wr_data_out)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge system_clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    case (state)
      IDLE: begin
        if (capture_arm_in || continuous_in) begin
          state_nxt = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        busy_out = 1'b1;
        // The first frame we keep must start on a boundary, so the frame in
        // flight when we were armed is skipped.
        if (frame_done_in) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        busy_out = 1'b1;
        if (frame_done_in) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        // continuous_in is only consulted here, so dropping it mid-frame
        // lets the current frame finish and commit.
        state_nxt = continuous_in ? CAPTURE : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pixel counter: counts issued writes in CAPTURE, still valid during COMMIT,
  // cleared everywhere else. Sticks at all-ones so a runaway stream with
  // repeated coordinates cannot wrap back onto the complete-frame value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge system_clk_in) begin
    if (rst_in) begin
      pix_cnt <= '0;
    end else if (state == CAPTURE) begin
      if (accept && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + 17'd1;
      end
    end else if (state != COMMIT) begin
      pix_cnt <= '0;
    end else begin
      pix_cnt <= '0;
    end
  end

  assign frame_complete = (pix_cnt == FRAME_PIXELS);

  // A release arriving in the COMMIT cycle frees the reader bank first, so a
  // complete frame can be handed over in that same cycle.
  assign reader_free = !frame_ready || read_release_in;

  // ---------------------------------------------------------------------------
  // Bank ownership, ready flag and drop counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge system_clk_in) begin
    if (rst_in) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      dropped     <= 8'd0;
    end else begin
      if (read_release_in) begin
        frame_ready <= 1'b0;
      end
      if (state == COMMIT) begin
        if (frame_complete && reader_free) begin
          // Banks only ever trade places, which keeps them distinct.
          rd_bank     <= wr_bank;
          wr_bank     <= ~wr_bank;
          frame_ready <= 1'b1;
        end else if (dropped != 8'hFF) begin
          // Short frame or reader still busy: keep the write bank, so the
          // next frame simply overwrites it.
          dropped <= dropped + 8'd1;
        end
      end
    end
  end

  assign wr_bank_out        = wr_bank;
  assign rd_bank_out        = rd_bank;
  assign frame_ready_out    = frame_ready;
  assign dropped_frames_out = dropped;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl. Geometry is scaled to 20x12 (240 pixels,
// 8-bit address) so whole frames and hundreds of drops fit in a short run; the
// corner pixel (19,11) plays the role of (319,239) and lands at address 239.
module tb_frame_capture_ctrl;

  localparam int H  = 20;
  localparam int V  = 12;
  localparam int PW = 7;
  localparam int AW = 8;
  localparam int FP = H * V;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pixel;
  logic          valid;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          frame_done;
  logic          capture_arm;
  logic          continuous;
  logic          read_release;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [PW-1:0] wr_data_out;
  logic          wr_bank_out;
  logic          rd_bank_out;
  logic          frame_ready_out;
  logic          busy_out;
  logic [7:0]    dropped_frames_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_capture_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .PIXEL_W  (PW),
    .ADDR_W   (AW)
  ) dut (
    .system_clk_in      (clk),
    .rst_in             (rst),
    .pixel_in           (pixel),
    .data_valid_in      (valid),
    .hcount_in          (hcount),
    .vcount_in          (vcount),
    .frame_done_in      (frame_done),
    .capture_arm_in     (capture_arm),
    .continuous_in      (continuous),
    .read_release_in    (read_release),
    .wr_en_out          (wr_en_out),
    .wr_addr_out        (wr_addr_out),
    .wr_data_out        (wr_data_out),
    .wr_bank_out        (wr_bank_out),
    .rd_bank_out        (rd_bank_out),
    .frame_ready_out    (frame_ready_out),
    .busy_out           (busy_out),
    .dropped_frames_out (dropped_frames_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic wb, input logic rb, input logic rdy,
                             input logic [7:0] drop, input logic busy);
    check_eq({tag, "_wr_bank"}, 32'(wr_bank_out), 32'(wb));
    check_eq({tag, "_rd_bank"}, 32'(rd_bank_out), 32'(rb));
    check_eq({tag, "_ready"},   32'(frame_ready_out), 32'(rdy));
    check_eq({tag, "_dropped"}, 32'(dropped_frames_out), 32'(drop));
    check_eq({tag, "_busy"},    32'(busy_out), 32'(busy));
  endtask

  // Streams n raster-ordered pixels, one per cycle; each must (or must not) show
  // up as a write one cycle later at address i in bank exp_bank. Optionally ends
  // with frame_done, with read_release placed in the COMMIT cycle.
  task automatic send_frame(input string tag, input int n, input bit exp_wr, input logic exp_bank,
                            input bit do_done, input bit rel, input int cont_off_at);
    int bad = 0;
    int nwr = 0;
    for (int i = 0; i < n; i++) begin
      logic [PW-1:0] p;
      p = PW'(i * 37 + 5);
      if (i == cont_off_at) continuous = 1'b0;
      valid  = 1'b1;
      hcount = 11'(i % H);
      vcount = 10'(i / H);
      pixel  = p;
      step();
      if (wr_en_out === 1'b1) nwr++;
      if (wr_en_out !== exp_wr) bad++;
      else if (exp_wr && (wr_addr_out !== AW'(i) || wr_data_out !== p || wr_bank_out !== exp_bank)) bad++;
    end
    valid = 1'b0;
    if (do_done) begin
      frame_done = 1'b1;
      step();
      if (wr_en_out !== 1'b0) bad++;
      frame_done   = 1'b0;
      read_release = rel;
      step();
      read_release = 1'b0;
      if (wr_en_out !== 1'b0) bad++;
    end
    check_eq({tag, "_wr_seq"}, 32'(bad), 32'd0);
    check_eq({tag, "_wr_cnt"}, 32'(nwr), exp_wr ? 32'(n) : 32'd0);
  endtask

  task automatic pulse_release();
    read_release = 1'b1;
    step();
    read_release = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pixel = '0; valid = 1'b0; hcount = '0; vcount = '0;
    frame_done = 1'b0; capture_arm = 1'b0; continuous = 1'b0; read_release = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset values.
    check_eq("rst_wr_en", 32'(wr_en_out), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr_out), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data_out), 32'd0);
    check_state("rst", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

    // Continuous capture: pixels before the first boundary are ignored.
    continuous = 1'b1;
    step();
    check_eq("sof_busy", 32'(busy_out), 32'd1);
    send_frame("sof_wait", 30, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    // First complete frame goes to bank 0 and is handed over.
    send_frame("frame_a", FP, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    check_state("frame_a", 1'b1, 1'b0, 1'b1, 8'd0, 1'b1);

    // Second complete frame into bank 1, reader never released: dropped.
    send_frame("frame_b", FP, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    check_state("frame_b", 1'b1, 1'b0, 1'b1, 8'd1, 1'b1);

    // Address corner and out-of-range pixels.
    valid = 1'b1; hcount = 11'd19; vcount = 10'd11; pixel = 7'h2A;
    step();
    check_eq("corner_wr_en", 32'(wr_en_out), 32'd1);
    check_eq("corner_addr", 32'(wr_addr_out), 32'd239);
    check_eq("corner_data", 32'(wr_data_out), 32'h2A);
    check_eq("corner_bank", 32'(wr_bank_out), 32'd1);
    hcount = 11'd20; vcount = 10'd0;
    step();
    check_eq("h_oob_wr_en", 32'(wr_en_out), 32'd0);
    hcount = 11'd0; vcount = 10'd12;
    step();
    check_eq("v_oob_wr_en", 32'(wr_en_out), 32'd0);
    hcount = 11'd0; vcount = 10'd0; pixel = 7'h11;
    step();
    check_eq("origin_wr_en", 32'(wr_en_out), 32'd1);
    check_eq("origin_addr", 32'(wr_addr_out), 32'd0);
    check_eq("origin_data", 32'(wr_data_out), 32'h11);
    // Pixel coincident with frame_done is discarded; 2-pixel frame is short.
    hcount = 11'd3; frame_done = 1'b1;
    step();
    check_eq("done_pixel_wr_en", 32'(wr_en_out), 32'd0);
    valid = 1'b0; frame_done = 1'b0;
    step();
    check_state("tiny", 1'b1, 1'b0, 1'b1, 8'd2, 1'b1);

    // Release, then a short frame with the reader bank free: still no swap.
    pulse_release();
    check_eq("release_ready", 32'(frame_ready_out), 32'd0);
    send_frame("short", 100, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    check_state("short", 1'b1, 1'b0, 1'b0, 8'd3, 1'b1);

    // Complete frame with reader free swaps.
    send_frame("frame_c", FP, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    check_state("frame_c", 1'b0, 1'b1, 1'b1, 8'd3, 1'b1);

    // Release in the COMMIT cycle: swap still happens, ready stays high.
    send_frame("frame_d", FP, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    check_state("frame_d", 1'b1, 1'b0, 1'b1, 8'd3, 1'b1);

    // continuous drops mid-frame: frame finishes, commits (dropped, reader busy), then idle.
    send_frame("frame_e", FP, 1'b1, 1'b1, 1'b1, 1'b0, 100);
    check_state("frame_e", 1'b1, 1'b0, 1'b1, 8'd4, 1'b0);

    pulse_release();
    send_frame("idle", 30, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    check_state("idle", 1'b1, 1'b0, 1'b0, 8'd4, 1'b0);

    // Single-shot arm in the middle of a frame: nothing until the boundary, then one frame.
    send_frame("pre_arm", 20, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    capture_arm = 1'b1;
    step();
    capture_arm = 1'b0;
    check_eq("arm_busy", 32'(busy_out), 32'd1);
    send_frame("armed_wait", 50, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    send_frame("frame_f", FP, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    check_state("frame_f", 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
    send_frame("post_single", 30, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    check_eq("post_single_busy", 32'(busy_out), 32'd0);

    // 300 empty frames in continuous mode: drop counter saturates.
    continuous = 1'b1;
    step();
    for (int k = 0; k < 301; k++) begin
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      step();
      step();
      if (k == 100) check_eq("drop_100", 32'(dropped_frames_out), 32'd104);
    end
    check_state("sat", 1'b0, 1'b1, 1'b1, 8'd255, 1'b1);

    // Reset in the middle of a frame, with a live pixel on the reset cycle.
    send_frame("rst_pre", 100, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    rst = 1'b1; valid = 1'b1; hcount = 11'd5; vcount = 10'd3; pixel = 7'h7F;
    step();
    check_eq("mid_rst_wr_en", 32'(wr_en_out), 32'd0);
    check_eq("mid_rst_wr_addr", 32'(wr_addr_out), 32'd0);
    check_eq("mid_rst_wr_data", 32'(wr_data_out), 32'd0);
    check_state("mid_rst", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    rst = 1'b0; valid = 1'b0; continuous = 1'b0;
    step();
    check_eq("post_rst_busy", 32'(busy_out), 32'd0);
    check_eq("post_rst_dropped", 32'(dropped_frames_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
